// File: rtl/alu_pkg.sv
// Shared opcode map and FSM state encoding for the registered ALU.
// Imported by alu_mul_iter and alu_multicycle.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, reset, start, a, b -> done, product[2*WIDTH-1:0].
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               busy;
    logic [2*WIDTH-1:0] acc_nxt;

    // product includes the current iteration so the final sum can be
    // registered by the parent on the same edge that retires the last bit
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    assign product = acc_nxt;
    assign done    = busy && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (cnt == LAST) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready input, flags and multi-cycle multiply.
// Ports: clk, reset, in_valid/in_ready, a, b, CarryIn, control -> out_valid, result, CarryOut, zero, overflow.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             CarryIn,
    input  logic [3:0]       control,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             CarryOut,
    output logic             zero,
    output logic             overflow
);

    state_t state;

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] mul_hi;

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_co;
    logic             alu_ov;
    logic             alu_z;
    logic             known;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (control == OP_MUL);
    assign mul_lo    = mul_prod[WIDTH-1:0];
    assign mul_hi    = mul_prod[2*WIDTH-1:WIDTH];

    alu_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (mul_start),
        .a      (a),
        .b      (b),
        .done   (mul_done),
        .product(mul_prod)
    );

    // shared adder: SUB is a + ~b + CarryIn
    assign bx  = (control == OP_SUB) ? ~b : b;
    assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, CarryIn};

    always_comb begin
        alu_res = '0;
        alu_co  = 1'b0;
        alu_ov  = 1'b0;
        known   = 1'b1;
        unique case (control)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD, OP_SUB: begin
                alu_res = sum[WIDTH-1:0];
                alu_co  = sum[WIDTH];
                alu_ov  = (a[WIDTH-1] == bx[WIDTH-1])
                       && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: begin
                alu_res = {{(WIDTH-1){1'b0}},
                           ($signed(a) < $signed(b))};
            end
            default: known = 1'b0;
        endcase
        // undefined opcodes report all flags clear
        alu_z = known && (alu_res == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            result    <= '0;
            CarryOut  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (control == OP_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            CarryOut  <= alu_co;
                            overflow  <= alu_ov;
                            zero      <= alu_z;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result    <= mul_lo;
                        CarryOut  <= |mul_hi;
                        overflow  <= 1'b0;
                        zero      <= (mul_lo == '0);
                        out_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at WIDTH=8 and WIDTH=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_alu_multicycle;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        v8 = 1'b0;
    logic        rdy8;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        ci8 = 1'b0;
    logic [3:0]  ctl8 = '0;
    logic        ov8;
    logic [7:0]  r8;
    logic        co8;
    logic        z8;
    logic        of8;

    logic        v16 = 1'b0;
    logic        rdy16;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        ci16 = 1'b0;
    logic [3:0]  ctl16 = '0;
    logic        ov16;
    logic [15:0] r16;
    logic        co16;
    logic        z16;
    logic        of16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(v8), .in_ready(rdy8),
        .a(a8), .b(b8), .CarryIn(ci8), .control(ctl8),
        .out_valid(ov8), .result(r8), .CarryOut(co8),
        .zero(z8), .overflow(of8)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset),
        .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16), .CarryIn(ci16), .control(ctl16),
        .out_valid(ov16), .result(r16), .CarryOut(co16),
        .zero(z16), .overflow(of16)
    );

    // drive one op at posedge+1, return at next posedge+1 with in_valid low
    task automatic op8(input logic [3:0] c, input logic [7:0] x,
                       input logic [7:0] y, input logic ci);
        v8 = 1'b1; ctl8 = c; a8 = x; b8 = y; ci8 = ci;
        @(posedge clk); #1;
        v8 = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({ov8, r8, co8, z8, of8} !== 12'h0) begin
            failures++;
            $display("FAIL reset_outs: got %b%h%b%b%b want 0",
                     ov8, r8, co8, z8, of8);
        end
        checks++;
        if (rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", rdy8);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        logic [7:0] exp [4];
        logic [3:0] ops [4];
        ops[0] = 4'b0000; exp[0] = 8'h0A;
        ops[1] = 4'b0001; exp[1] = 8'h1E;
        ops[2] = 4'b1100; exp[2] = 8'hE1;
        ops[3] = 4'b0010; exp[3] = 8'h28;
        a8 = 8'd10; b8 = 8'd30; ci8 = 1'b0; v8 = 1'b1;
        ctl8 = ops[0];
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) ctl8 = ops[i+1];
            else v8 = 1'b0;
            checks++;
            if (ov8 !== 1'b1 || r8 !== exp[i]) begin
                failures++;
                $display("FAIL stream%0d: valid=%b res=%h want 1 %h",
                         i, ov8, r8, exp[i]);
            end
        end
        checks++;
        if (co8 !== 1'b0) begin
            failures++;
            $display("FAIL stream_add_co: got %b want 0", co8);
        end
        @(posedge clk); #1;
        checks++;
        if (ov8 !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: valid=%b want 0", ov8);
        end
    endtask

    task automatic test_sub;
        op8(4'b0110, 8'd10, 8'd30, 1'b1);
        checks++;
        if ({r8, co8, of8, z8} !== {8'hEC, 3'b000}) begin
            failures++;
            $display("FAIL sub_neg: res=%h co=%b ov=%b z=%b want ec 0 0 0",
                     r8, co8, of8, z8);
        end
        op8(4'b0110, 8'd30, 8'd30, 1'b1);
        checks++;
        if ({r8, z8, co8} !== {8'h00, 2'b11}) begin
            failures++;
            $display("FAIL sub_eq: res=%h z=%b co=%b want 00 1 1",
                     r8, z8, co8);
        end
    endtask

    task automatic test_flags;
        op8(4'b0010, 8'd200, 8'd100, 1'b0);
        checks++;
        if (r8 !== 8'h2C || co8 !== 1'b1) begin
            failures++;
            $display("FAIL add_carry: res=%h co=%b want 2c 1", r8, co8);
        end
        op8(4'b0010, 8'd127, 8'd1, 1'b0);
        checks++;
        if (r8 !== 8'h80 || of8 !== 1'b1) begin
            failures++;
            $display("FAIL add_ovf: res=%h ov=%b want 80 1", r8, of8);
        end
        op8(4'b0111, 8'hF6, 8'h05, 1'b0);
        checks++;
        if (r8 !== 8'h01 || co8 !== 1'b0 || of8 !== 1'b0) begin
            failures++;
            $display("FAIL slt: res=%h co=%b ov=%b want 01 0 0",
                     r8, co8, of8);
        end
        op8(4'b1111, 8'hFF, 8'hFF, 1'b1);
        checks++;
        if (ov8 !== 1'b1 || r8 !== 8'h00 || co8 !== 1'b0 || of8 !== 1'b0) begin
            failures++;
            $display("FAIL illegal: valid=%b res=%h co=%b ov=%b want 1 00 0 0",
                     ov8, r8, co8, of8);
        end
    endtask

    task automatic test_mul;
        v8 = 1'b1; ctl8 = 4'b1000; a8 = 8'd10; b8 = 8'd30; ci8 = 1'b0;
        @(posedge clk); #1;
        // an ADD held on the input while the multiply is busy
        ctl8 = 4'b0010; a8 = 8'd1; b8 = 8'd1;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 7) v8 = 1'b0;
            checks++;
            if (ov8 !== (k == 8) || rdy8 !== (k == 8)) begin
                failures++;
                $display("FAIL mul_cycle%0d: valid=%b ready=%b want %b %b",
                         k, ov8, rdy8, (k == 8), (k == 8));
            end
        end
        checks++;
        if (r8 !== 8'h2C || co8 !== 1'b1 || of8 !== 1'b0) begin
            failures++;
            $display("FAIL mul_res: res=%h co=%b ov=%b want 2c 1 0",
                     r8, co8, of8);
        end
        @(posedge clk); #1;
        checks++;
        if (ov8 !== 1'b0 || r8 !== 8'h2C) begin
            failures++;
            $display("FAIL mul_extra: valid=%b res=%h want 0 2c", ov8, r8);
        end
    endtask

    task automatic test_mul_reset;
        int seen;
        seen = 0;
        v8 = 1'b1; ctl8 = 4'b1000; a8 = 8'd10; b8 = 8'd30;
        @(posedge clk); #1;
        v8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ov8, r8, co8, z8, of8} !== 12'h0 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: out=%b%h%b%b%b ready=%b want 0 1",
                     ov8, r8, co8, z8, of8, rdy8);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ov8 !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_valid: pulses=%0d want 0", seen);
        end
        op8(4'b0010, 8'd1, 8'd1, 1'b0);
        checks++;
        if (ov8 !== 1'b1 || r8 !== 8'h02) begin
            failures++;
            $display("FAIL post_reset_add: valid=%b res=%h want 1 02",
                     ov8, r8);
        end
    endtask

    task automatic test_width16;
        int lat;
        lat = 0;
        v16 = 1'b1; ctl16 = 4'b1000; a16 = 16'hFFFF; b16 = 16'hFFFF;
        @(posedge clk); #1;
        v16 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ov16 === 1'b1) begin
                lat = n;
                break;
            end
        end
        checks++;
        if (lat != 16) begin
            failures++;
            $display("FAIL w16_latency: got %0d want 16", lat);
        end
        checks++;
        if (r16 !== 16'h0001 || co16 !== 1'b1) begin
            failures++;
            $display("FAIL w16_mul: res=%h co=%b want 0001 1", r16, co16);
        end
        v16 = 1'b1; ctl16 = 4'b0010; a16 = 16'hFFFF; b16 = 16'h0001;
        ci16 = 1'b0;
        @(posedge clk); #1;
        v16 = 1'b0;
        checks++;
        if (r16 !== 16'h0000 || z16 !== 1'b1 || co16 !== 1'b1
            || of16 !== 1'b0) begin
            failures++;
            $display("FAIL w16_add: res=%h z=%b co=%b ov=%b want 0000 1 1 0",
                     r16, z16, co16, of16);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_sub;
        test_flags;
        test_mul;
        test_mul_reset;
        test_width16;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
